// File: rtl/uart_byte_rx_pkg.sv
// uart_byte_rx_pkg
//   Shared definitions for the UART byte receiver: FSM state encoding,
//   oversample ratio, divisor width and the Baud_Set -> divisor table.
package uart_byte_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam int DIV_W      = 16;

  // Baud_Set decode; 5..7 fall back to 9600.
  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      3'd1:    return 19200;
      3'd2:    return 38400;
      3'd3:    return 57600;
      3'd4:    return 115200;
      default: return 9600;
    endcase
  endfunction

  // Divisor = round(clk / (16 * baud)) - 1. At 50 MHz this gives the
  // table 325 / 162 / 80 / 53 / 26 for Baud_Set 0..4.
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_freq,
                                                input logic [2:0]  sel);
    int unsigned ovs;
    ovs = OVERSAMPLE * baud_rate(sel);
    return DIV_W'((clk_freq + ovs / 2) / ovs - 1);
  endfunction

endpackage

// File: rtl/uart_byte_rx_bps_gen.sv
// rx_bps_gen
//   16x oversample tick generator. Counter is held at 0 while en is low,
//   so the first tick lands div+1 clocks after en rises.
//   clk, rst_n : clock, async active-low reset
//   div        : ticks-minus-1 divisor (latched by the parent)
//   en         : run enable
//   tick       : one-clock pulse every div+1 clocks while enabled
module rx_bps_gen
  import uart_byte_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || cnt_q == div) cnt_d = '0;
    else                     cnt_d = cnt_q + 1'b1;
  end

  assign tick = en && (cnt_q == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx
//   8N1 UART receiver with 16x oversampling and 2-of-3 majority per bit.
//   Clk        : system clock
//   Rst_n      : async active-low reset
//   Baud_Set   : baud select, latched on start-edge detection
//   Rs232_Rx   : serial line (async, idle high)
//   Data_Byte  : last correctly received byte
//   Rx_Done    : one-clock pulse on Data_Byte update
//   Frame_Err  : one-clock pulse when the stop bit samples low
//   Rx_Busy    : high whenever the FSM is not IDLE
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [2:0] Baud_Set,
  input  logic       Rs232_Rx,
  output logic [7:0] Data_Byte,
  output logic       Rx_Done,
  output logic       Frame_Err,
  output logic       Rx_Busy
);

  localparam logic [DIV_W-1:0] DIV_0 = baud_div(CLK_FREQ, 3'd0);
  localparam logic [DIV_W-1:0] DIV_1 = baud_div(CLK_FREQ, 3'd1);
  localparam logic [DIV_W-1:0] DIV_2 = baud_div(CLK_FREQ, 3'd2);
  localparam logic [DIV_W-1:0] DIV_3 = baud_div(CLK_FREQ, 3'd3);
  localparam logic [DIV_W-1:0] DIV_4 = baud_div(CLK_FREQ, 3'd4);

  rx_state_e         state_q, state_d;
  logic              rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [1:0]        fill_q, fill_d;
  logic              line_ok_q, line_ok_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        smp_q, smp_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_byte_q, data_byte_d;
  logic              rx_done_q, rx_done_d, frame_err_q, frame_err_d;

  logic              tick, maj, start_edge;
  logic [DIV_W-1:0]  div_sel;

  rx_bps_gen u_bps (
    .clk   (Clk),
    .rst_n (Rst_n),
    .div   (div_q),
    .en    (state_q != ST_IDLE),
    .tick  (tick)
  );

  always_comb begin
    case (Baud_Set)
      3'd1:    div_sel = DIV_1;
      3'd2:    div_sel = DIV_2;
      3'd3:    div_sel = DIV_3;
      3'd4:    div_sel = DIV_4;
      default: div_sel = DIV_0;
    endcase
  end

  // Majority of ticks 7, 8 and the live tick-9 sample.
  assign maj = (smp_q[0] & smp_q[1]) | (rx_s2_q & (smp_q[0] | smp_q[1]));

  // Start only after the line has genuinely been seen high: fill_q marks
  // that rx_s2_q now reflects the line rather than its reset value, and
  // line_ok_q is dropped by a frame error until the line recovers.
  assign start_edge = line_ok_q && rx_prev_q && !rx_s2_q;

  always_comb begin
    state_d     = state_q;
    rx_s1_d     = Rs232_Rx;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    fill_d      = {fill_q[0], 1'b1};
    line_ok_d   = line_ok_q;
    div_d       = div_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    smp_d       = smp_q;
    shift_d     = shift_q;
    data_byte_d = data_byte_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    if (state_q == ST_IDLE && fill_q == 2'b11 && rx_s2_q) line_ok_d = 1'b1;

    if (state_q == ST_IDLE) begin
      if (start_edge) begin
        state_d    = ST_START;
        div_d      = div_sel;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + 1'b1;
      if (tick_cnt_q == TICK_W'(7)) smp_d[0] = rx_s2_q;
      if (tick_cnt_q == TICK_W'(8)) smp_d[1] = rx_s2_q;
      if (tick_cnt_q == TICK_W'(9)) begin
        case (state_q)
          ST_START: if (maj) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
          end
          ST_DATA:  shift_d = {maj, shift_q[7:1]};
          ST_STOP: begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            if (maj) begin
              data_byte_d = shift_q;
              rx_done_d   = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              line_ok_d   = 1'b0;
            end
          end
          default: ;
        endcase
      end
      if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
        case (state_q)
          ST_START: begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
          ST_DATA: begin
            if (bit_cnt_q == 3'd7) state_d = ST_STOP;
            else                   bit_cnt_d = bit_cnt_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      fill_q      <= '0;
      line_ok_q   <= 1'b0;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      smp_q       <= '0;
      shift_q     <= '0;
      data_byte_q <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      fill_q      <= fill_d;
      line_ok_q   <= line_ok_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      smp_q       <= smp_d;
      shift_q     <= shift_d;
      data_byte_q <= data_byte_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign Data_Byte = data_byte_q;
  assign Rx_Done   = rx_done_q;
  assign Frame_Err = frame_err_q;
  assign Rx_Busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx
//   Directed bench for uart_byte_rx: a bit-banged transmitter drives the
//   line, a negedge monitor logs pulses, and immediate assertions check
//   reset state, received bytes, glitch rejection, frame errors, baud
//   tolerance and mid-frame reset.
module tb_uart_byte_rx;

  localparam int B4 = 27 * 16;   // 115200 bit time in clocks
  localparam int B3 = 54 * 16;   // 57600
  localparam int T0 = 326;       // 9600 tick in clocks

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [2:0] Baud_Set = 3'd4;
  logic       Rs232_Rx = 1'b1;
  logic [7:0] Data_Byte;
  logic       Rx_Done, Frame_Err, Rx_Busy;

  int checks = 0;
  int errors = 0;

  uart_byte_rx #(.CLK_FREQ(50_000_000)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Baud_Set  (Baud_Set),
    .Rs232_Rx  (Rs232_Rx),
    .Data_Byte (Data_Byte),
    .Rx_Done   (Rx_Done),
    .Frame_Err (Frame_Err),
    .Rx_Busy   (Rx_Busy)
  );

  always #10 Clk = ~Clk;

  // Pulse monitor
  int         done_cnt = 0, ferr_cnt = 0, overlap_cnt = 0, bad_chg_cnt = 0;
  logic [7:0] rx_log[$];
  logic [7:0] prev_byte = 8'h00;

  always @(negedge Clk) begin
    if (Rx_Done) begin
      done_cnt++;
      rx_log.push_back(Data_Byte);
    end
    if (Frame_Err) ferr_cnt++;
    if (Rx_Done && Frame_Err) overlap_cnt++;
    if (Rst_n && Data_Byte !== prev_byte && !Rx_Done) bad_chg_cnt++;
    prev_byte = Data_Byte;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    Rs232_Rx = b;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic stop_b,
                            input logic do_alt, input logic [2:0] alt_baud);
    logic [2:0] keep;
    keep = Baud_Set;
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) begin
      if (do_alt && i == 3) Baud_Set = alt_baud;
      drive_bit(d[i], n);
    end
    Baud_Set = keep;
    drive_bit(stop_b, n);
  endtask

  function automatic logic [31:0] log_at(input int idx);
    if (idx < rx_log.size()) return {24'h0, rx_log[idx]};
    return 32'hDEAD;
  endfunction

  initial begin
    int d0, f0, waited;

    // Reset state
    repeat (5) @(posedge Clk);
    #1;
    chk("rst_data", Data_Byte, 8'h00);
    chk("rst_done", Rx_Done, 1'b0);
    chk("rst_ferr", Frame_Err, 1'b0);
    chk("rst_busy", Rx_Busy, 1'b0);
    Rst_n = 1'b1;
    drive_bit(1'b1, 20);

    // 115200, 0xA5
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, B4, 1'b1, 1'b0, 3'd4);
    drive_bit(1'b1, 40);
    chk("a5_done_cnt", done_cnt - d0, 1);
    chk("a5_data", Data_Byte, 8'hA5);
    chk("a5_ferr_cnt", ferr_cnt - f0, 0);
    chk("a5_busy", Rx_Busy, 1'b0);

    // Back-to-back 57600; Baud_Set flips to 4 in the middle of frame 2
    Baud_Set = 3'd3;
    drive_bit(1'b1, 20);
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h00, B3, 1'b1, 1'b0, 3'd3);
    send_frame(8'hFF, B3, 1'b1, 1'b1, 3'd4);
    send_frame(8'h55, B3, 1'b1, 1'b0, 3'd3);
    drive_bit(1'b1, 40);
    chk("b2b_done_cnt", done_cnt - d0, 3);
    chk("b2b_byte0", log_at(d0), 32'h00);
    chk("b2b_byte1", log_at(d0 + 1), 32'hFF);
    chk("b2b_byte2", log_at(d0 + 2), 32'h55);
    chk("b2b_ferr_cnt", ferr_cnt - f0, 0);

    // 9600 glitch: 4 ticks low
    Baud_Set = 3'd0;
    drive_bit(1'b1, 20);
    d0 = done_cnt; f0 = ferr_cnt;
    drive_bit(1'b0, 2 * T0);
    chk("glitch_busy_up", Rx_Busy, 1'b1);
    drive_bit(1'b0, 2 * T0);
    Rs232_Rx = 1'b1;
    waited = 0;
    while (Rx_Busy && waited < 12 * T0) begin
      @(negedge Clk);
      waited++;
    end
    chk("glitch_busy_drop", Rx_Busy, 1'b0);
    drive_bit(1'b1, 4 * T0);
    chk("glitch_done_cnt", done_cnt - d0, 0);
    chk("glitch_ferr_cnt", ferr_cnt - f0, 0);

    // Frame error: 0x3C with low stop, line then held low
    Baud_Set = 3'd4;
    drive_bit(1'b1, 20);
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, B4, 1'b0, 1'b0, 3'd4);
    drive_bit(1'b0, 3 * B4);
    chk("ferr_cnt", ferr_cnt - f0, 1);
    chk("ferr_done_cnt", done_cnt - d0, 0);
    chk("ferr_data_kept", Data_Byte, 8'h55);
    chk("ferr_busy_low", Rx_Busy, 1'b0);
    drive_bit(1'b1, B4);
    send_frame(8'h3C, B4, 1'b1, 1'b0, 3'd4);
    drive_bit(1'b1, 40);
    chk("post_ferr_data", Data_Byte, 8'h3C);
    chk("post_ferr_done_cnt", done_cnt - d0, 1);

    // +/-3 % transmitter baud error at 115200
    d0 = done_cnt;
    send_frame(8'hC3, 445, 1'b1, 1'b0, 3'd4);
    drive_bit(1'b1, B4);
    chk("slow_done_cnt", done_cnt - d0, 1);
    chk("slow_data", Data_Byte, 8'hC3);
    send_frame(8'hC3, 419, 1'b1, 1'b0, 3'd4);
    drive_bit(1'b1, B4);
    chk("fast_done_cnt", done_cnt - d0, 2);
    chk("fast_data", log_at(d0 + 1), 32'hC3);

    // Reset during data bit 4, then 0x81
    d0 = done_cnt; f0 = ferr_cnt;
    drive_bit(1'b0, B4);
    for (int i = 0; i < 4; i++) drive_bit(1'b1 ^ (i == 0 ? 1'b0 : 1'b1), B4);
    drive_bit(1'b0, B4 / 2);
    chk("mid_busy", Rx_Busy, 1'b1);
    Rst_n = 1'b0;
    Rs232_Rx = 1'b1;
    #5;
    chk("mid_rst_data", Data_Byte, 8'h00);
    chk("mid_rst_busy", Rx_Busy, 1'b0);
    drive_bit(1'b1, 10);
    Rst_n = 1'b1;
    drive_bit(1'b1, 2 * B4);
    chk("mid_rst_done_cnt", done_cnt - d0, 0);
    chk("mid_rst_ferr_cnt", ferr_cnt - f0, 0);
    chk("mid_rst_data_idle", Data_Byte, 8'h00);
    send_frame(8'h81, B4, 1'b1, 1'b0, 3'd4);
    drive_bit(1'b1, 40);
    chk("post_rst_data", Data_Byte, 8'h81);
    chk("post_rst_done_cnt", done_cnt - d0, 1);

    // Global invariants
    chk("overlap_cnt", overlap_cnt, 0);
    chk("bad_data_change", bad_chg_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
